memctl: RTL and testbench

Backing-memory controller for the L1 fill queue. It sits directly downstream of the memory unit's fill queue: it consumes every `t_mem_req_pkt` the fill queue emits, buffers it in a small in-order FIFO, services requests one at a time against a line-granular backing array after a programmable latency, and returns a `t_mem_rsp_pkt` that the fill queue consumes. There is no backpressure toward the fill queue, so overflow is detected and flagged rather than stalled.

---
 rtl/memctl_pkg.sv | 37 +++
 rtl/memctl_fifo.sv | 58 +++++
 rtl/memctl.sv | 142 ++++++++++++++
 tb/tb_memctl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memctl_pkg.sv
// Memory-side packet types shared by the L1 fill queue and memctl.
package mem_common;

  localparam int unsigned CL_BITS        = 64;
  localparam int unsigned ID_BITS        = 4;
  localparam int unsigned LINE_ADDR_BITS = 26;

  typedef logic [CL_BITS-1:0]        t_cl;
  typedef logic [ID_BITS-1:0]        t_mem_id;
  typedef logic [LINE_ADDR_BITS-1:0] t_line_addr;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } t_mem_op;

  typedef struct packed {
    logic       valid;
    t_mem_op    op;
    t_mem_id    id;
    t_line_addr addr;
    t_cl        data;
  } t_mem_req_pkt;

  typedef struct packed {
    logic    valid;
    t_mem_op op;
    t_mem_id id;
    t_cl     data;
  } t_mem_rsp_pkt;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/memctl_fifo.sv
// In-order request buffer for memctl; a push on a full FIFO succeeds only with a same-cycle pop.
module memctl_fifo
  import mem_common::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = t_mem_req_pkt
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  T                         wdata_i,
  output T                         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [PW:0]    count_q;
  logic           do_push_s;
  logic           do_pop_s;

  assign full_o    = (count_q == (PW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push_s && !do_pop_s) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop_s && !do_push_s) begin
        count_q <= count_q - 1'b1;
      end else begin
        count_q <= count_q;
      end
    end
  end

  // Payload storage needs no reset; only pointer-qualified entries are ever read.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/memctl.sv
// Backing-memory controller: FIFO-buffered, one-at-a-time service after a programmable latency.
// Optional MEMCTL_LAT_JITTER_EN adds 0..3 cycles of LFSR-driven latency per request.
module memctl
  import mem_common::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LATENCY   = 8,
  parameter int unsigned NUM_LINES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  t_mem_req_pkt mem_req_pkt,
  output t_mem_rsp_pkt mem_rsp_pkt,
  output logic         busy,
  output logic         ovf_err
);

  localparam int unsigned IW = $clog2(NUM_LINES);
  localparam int unsigned CW = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } t_memctl_state;

  t_memctl_state         state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  t_mem_req_pkt          svc_q, svc_d;
  t_mem_rsp_pkt          rsp_q, rsp_d;
  logic                  ovf_q, ovf_d;
  t_cl                   array_q [NUM_LINES];

  t_mem_req_pkt          head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [$clog2(DEPTH):0] fifo_count_s;
  logic                  pop_s;
  logic [1:0]            jit_s;
  logic                  unused_s;

  assign pop_s = (state_q == IDLE) && !fifo_empty_s;

  memctl_fifo #(
    .DEPTH (DEPTH),
    .T     (t_mem_req_pkt)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (mem_req_pkt.valid),
    .pop_i   (pop_s),
    .wdata_i (mem_req_pkt),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

`ifdef MEMCTL_LAT_JITTER_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'h01;
    end else if (pop_s) begin
      lfsr_q <= lfsr8_next(lfsr_q);
    end else begin
      lfsr_q <= lfsr_q;
    end
  end

  assign jit_s = lfsr_q[1:0];
`else
  assign jit_s = 2'b00;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    svc_d   = svc_q;
    rsp_d   = '0;
    ovf_d   = ovf_q | (mem_req_pkt.valid & fifo_full_s & ~pop_s);
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          svc_d   = head_s;
          cnt_d   = CW'(LATENCY - 2) + CW'(jit_s);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // The response register is loaded here so it is valid for exactly the RESP cycle.
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_d.valid = 1'b1;
          rsp_d.op    = svc_q.op;
          rsp_d.id    = svc_q.id;
          rsp_d.data  = (svc_q.op == MEM_RD) ? array_q[svc_q.addr[IW-1:0]] : '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      svc_q   <= '0;
      rsp_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      svc_q   <= svc_d;
      rsp_q   <= rsp_d;
      ovf_q   <= ovf_d;
    end
  end

  // A write retires on its RESP edge; a reset in that cycle discards it.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == RESP) && (svc_q.op == MEM_WR)) begin
      array_q[svc_q.addr[IW-1:0]] <= svc_q.data;
    end
  end

  assign unused_s    = ^{svc_q.valid, svc_q.addr[LINE_ADDR_BITS-1:IW]};
  assign busy        = (fifo_count_s != '0) || (state_q != IDLE);
  assign ovf_err     = ovf_q;
  assign mem_rsp_pkt = rsp_q;

endmodule

// File: tb/tb_memctl.sv
// Randomized self-checking bench for memctl against a queue-based timing/data model.
module tb_memctl;
  import mem_common::*;

  localparam int LAT = 8;
  localparam int DEP = 4;
  localparam int NL  = 1024;

  logic         clk = 1'b0;
  logic         reset;
  t_mem_req_pkt req;
  t_mem_rsp_pkt rsp;
  logic         busy;
  logic         ovf;

  memctl #(.DEPTH(DEP), .LATENCY(LAT), .NUM_LINES(NL)) dut (
    .clk(clk), .reset(reset), .mem_req_pkt(req), .mem_rsp_pkt(rsp), .busy(busy), .ovf_err(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: each accepted request knows its arrival, pop and response cycles.
  typedef struct {
    int      arr;
    int      pop;
    int      resp;
    t_mem_op op;
    t_mem_id id;
    int      idx;
    t_cl     data;
  } t_exp;

  t_exp         exp_q[$];
  t_cl          mem_m[int];
  int           last_resp;
  logic [7:0]   lfsr_m;
  bit           ovf_m;
  int           pred_resp;

  int           n_tests = 0;
  int           n_fail  = 0;

  t_mem_rsp_pkt exp_rsp, obs_rsp;
  bit           exp_dk, exp_busy, exp_ovf;
  logic         obs_busy, obs_ovf;
  int           obs_cyc;
  t_mem_req_pkt idle;

  task automatic tick(input bit rst, input t_mem_req_pkt r);
    int   c, occ, lat;
    bit   pop_now;
    t_exp e;
    @(negedge clk);
    c = cyc;
    obs_cyc = c; obs_rsp = rsp; obs_busy = busy; obs_ovf = ovf;
    exp_busy = 0; occ = 0; pop_now = 0;
    foreach (exp_q[i]) begin
      if (exp_q[i].arr < c && exp_q[i].resp >= c) exp_busy = 1;
      if (exp_q[i].arr < c && exp_q[i].pop >= c) occ++;
      if (exp_q[i].pop == c) pop_now = 1;
    end
    exp_ovf = ovf_m; exp_rsp = '0; exp_dk = 1;
    if (exp_q.size() > 0 && exp_q[0].resp == c) begin
      e = exp_q.pop_front();
      exp_rsp.valid = 1'b1; exp_rsp.op = e.op; exp_rsp.id = e.id;
      if (e.op == MEM_WR) begin
        if (!rst) mem_m[e.idx] = e.data;
      end else if (mem_m.exists(e.idx)) exp_rsp.data = mem_m[e.idx];
      else exp_dk = 0;
    end
    pred_resp = -1;
    if (rst) begin
      exp_q.delete(); last_resp = -100; lfsr_m = 8'h01; ovf_m = 0;
      reset = 1'b1; req = '0;
    end else begin
      reset = 1'b0; req = r;
      if (r.valid) begin
        if (occ < DEP || pop_now) begin
          e.arr = c;
          e.pop = (c + 1 > last_resp + 1) ? c + 1 : last_resp + 1;
          lat = LAT;
`ifdef MEMCTL_LAT_JITTER_EN
          lat = lat + int'(lfsr_m[1:0]);
          lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
`endif
          e.resp = e.pop + lat;
          e.op = r.op; e.id = r.id; e.idx = int'(r.addr) & (NL - 1); e.data = r.data;
          exp_q.push_back(e); last_resp = e.resp; pred_resp = e.resp;
        end else begin
          ovf_m = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    tick(1'b1, idle);
    tick(1'b0, idle);
    n_tests += 3;
    if (obs_rsp !== '0) begin n_fail++; $display("FAIL reset_rsp got=%h want=0", obs_rsp); end
    if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", obs_busy); end
    if (obs_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b want=0", obs_ovf); end
  endtask

  task automatic test_single_read();
    t_mem_req_pkt r;
    int n, er, rc, bf, bl;
    r = '0; r.valid = 1'b1; r.op = MEM_RD; r.id = 4'd3; r.addr = 26'h40;
    n = 0; er = 0; rc = -1; bf = -1; bl = -1;
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, (i == 0) ? r : idle);
      if (i == 0) begin n = obs_cyc; er = pred_resp; end
      n_tests += 3;
      if (obs_rsp.valid !== exp_rsp.valid || obs_rsp.op !== exp_rsp.op || obs_rsp.id !== exp_rsp.id || (exp_dk && obs_rsp.data !== exp_rsp.data)) begin n_fail++; $display("FAIL single_rsp cyc=%0d got=%h want=%h", obs_cyc, obs_rsp, exp_rsp); end
      if (obs_busy !== exp_busy) begin n_fail++; $display("FAIL single_busy cyc=%0d got=%b want=%b", obs_cyc, obs_busy, exp_busy); end
      if (obs_ovf !== exp_ovf) begin n_fail++; $display("FAIL single_ovf cyc=%0d got=%b want=%b", obs_cyc, obs_ovf, exp_ovf); end
      if (obs_rsp.valid === 1'b1) rc = obs_cyc;
      if (obs_busy === 1'b1) begin if (bf < 0) bf = obs_cyc; bl = obs_cyc; end
    end
    n_tests++;
    if (rc != er) begin n_fail++; $display("FAIL single_rsp_cycle got=%0d want=%0d", rc - n, er - n); end
`ifndef MEMCTL_LAT_JITTER_EN
    n_tests++;
    if (rc != n + LAT + 1) begin n_fail++; $display("FAIL single_latency got=%0d want=%0d", rc - n, LAT + 1); end
`endif
    n_tests++;
    if (bf != n + 1 || bl != rc) begin n_fail++; $display("FAIL single_busy_window got=%0d..%0d want=%0d..%0d", bf - n, bl - n, 1, rc - n); end
  endtask

  task automatic test_write_read();
    t_mem_req_pkt w, r;
    t_cl pat, rdat;
    int ew, er, wc, rc;
    pat = {8{8'hA5}};
    w = '0; w.valid = 1'b1; w.op = MEM_WR; w.id = 4'd5; w.addr = 26'h12; w.data = pat;
    r = '0; r.valid = 1'b1; r.op = MEM_RD; r.id = 4'd6; r.addr = 26'h12;
    ew = 0; er = 0; wc = -1; rc = -1; rdat = '0;
    for (int i = 0; i < 32; i++) begin
      tick(1'b0, (i == 0) ? w : ((i == 1) ? r : idle));
      if (i == 0) ew = pred_resp;
      if (i == 1) er = pred_resp;
      n_tests += 3;
      if (obs_rsp.valid !== exp_rsp.valid || obs_rsp.op !== exp_rsp.op || obs_rsp.id !== exp_rsp.id || (exp_dk && obs_rsp.data !== exp_rsp.data)) begin n_fail++; $display("FAIL wr_rd_rsp cyc=%0d got=%h want=%h", obs_cyc, obs_rsp, exp_rsp); end
      if (obs_busy !== exp_busy) begin n_fail++; $display("FAIL wr_rd_busy cyc=%0d got=%b want=%b", obs_cyc, obs_busy, exp_busy); end
      if (obs_ovf !== exp_ovf) begin n_fail++; $display("FAIL wr_rd_ovf cyc=%0d got=%b want=%b", obs_cyc, obs_ovf, exp_ovf); end
      if (obs_rsp.valid === 1'b1 && obs_rsp.id === 4'd5) wc = obs_cyc;
      if (obs_rsp.valid === 1'b1 && obs_rsp.id === 4'd6) begin rc = obs_cyc; rdat = obs_rsp.data; end
    end
    n_tests += 3;
    if (wc != ew) begin n_fail++; $display("FAIL wr_ack_cycle got=%0d want=%0d", wc, ew); end
    if (rc != er) begin n_fail++; $display("FAIL rd_rsp_cycle got=%0d want=%0d", rc, er); end
    if (rdat !== pat) begin n_fail++; $display("FAIL rd_after_wr_data got=%h want=%h", rdat, pat); end
`ifndef MEMCTL_LAT_JITTER_EN
    n_tests++;
    if (rc - wc != LAT + 1) begin n_fail++; $display("FAIL wr_rd_period got=%0d want=%0d", rc - wc, LAT + 1); end
`endif
  endtask

  task automatic test_burst(input int n);
    t_mem_req_pkt r;
    int seen, want_seen;
    seen = 0;
    for (int i = 0; i < n + 75; i++) begin
      r = '0;
      if (i < n) begin r.valid = 1'b1; r.op = MEM_RD; r.id = t_mem_id'(i); r.addr = 26'h12; end
      tick(1'b0, r);
      n_tests += 3;
      if (obs_rsp.valid !== exp_rsp.valid || obs_rsp.op !== exp_rsp.op || obs_rsp.id !== exp_rsp.id || (exp_dk && obs_rsp.data !== exp_rsp.data)) begin n_fail++; $display("FAIL burst_rsp cyc=%0d got=%h want=%h", obs_cyc, obs_rsp, exp_rsp); end
      if (obs_busy !== exp_busy) begin n_fail++; $display("FAIL burst_busy cyc=%0d got=%b want=%b", obs_cyc, obs_busy, exp_busy); end
      if (obs_ovf !== exp_ovf) begin n_fail++; $display("FAIL burst_ovf cyc=%0d got=%b want=%b", obs_cyc, obs_ovf, exp_ovf); end
      if (obs_rsp.valid === 1'b1) begin
        n_tests++;
        if (obs_rsp.id !== t_mem_id'(seen)) begin n_fail++; $display("FAIL burst_order got=%0d want=%0d", obs_rsp.id, seen); end
        seen++;
      end
    end
    want_seen = (n > DEP + 1) ? DEP + 1 : n;
    n_tests += 2;
    if (seen != want_seen) begin n_fail++; $display("FAIL burst_count n=%0d got=%0d want=%0d", n, seen, want_seen); end
    if (ovf !== ((n > DEP + 1) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL burst_ovf_final n=%0d got=%b", n, ovf); end
  endtask

  task automatic test_reset_in_wait();
    t_mem_req_pkt r;
    int seen, n2, er, rc;
    r = '0; r.valid = 1'b1; r.op = MEM_RD; r.id = 4'd7; r.addr = 26'h40;
    seen = 0; n2 = 0; er = 0; rc = -1;
    for (int i = 0; i < 27; i++) begin
      tick(i == 6, (i == 0) ? r : idle);
      n_tests += 3;
      if (obs_rsp.valid !== exp_rsp.valid || obs_rsp.op !== exp_rsp.op || obs_rsp.id !== exp_rsp.id || (exp_dk && obs_rsp.data !== exp_rsp.data)) begin n_fail++; $display("FAIL rst_wait_rsp cyc=%0d got=%h want=%h", obs_cyc, obs_rsp, exp_rsp); end
      if (obs_busy !== exp_busy) begin n_fail++; $display("FAIL rst_wait_busy cyc=%0d got=%b want=%b", obs_cyc, obs_busy, exp_busy); end
      if (obs_ovf !== exp_ovf) begin n_fail++; $display("FAIL rst_wait_ovf cyc=%0d got=%b want=%b", obs_cyc, obs_ovf, exp_ovf); end
      if (obs_rsp.valid === 1'b1) seen++;
      if (i == 7) begin
        n_tests++;
        if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL rst_wait_busy_after got=%b want=0", obs_busy); end
      end
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_wait_no_rsp got=%0d want=0", seen); end
    r.id = 4'd8;
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, (i == 0) ? r : idle);
      if (i == 0) begin n2 = obs_cyc; er = pred_resp; end
      if (obs_rsp.valid === 1'b1 && rc < 0) rc = obs_cyc;
    end
    n_tests++;
    if (rc != er) begin n_fail++; $display("FAIL rst_wait_next_latency got=%0d want=%0d", rc - n2, er - n2); end
  endtask

  task automatic test_latency();
    t_mem_req_pkt r;
    int n, er, rc, lo, hi;
    lo = LAT + 1; hi = LAT + 1;
`ifdef MEMCTL_LAT_JITTER_EN
    hi = LAT + 4;
`endif
    for (int k = 0; k < 16; k++) begin
      r = '0; r.valid = 1'b1; r.op = MEM_RD; r.id = t_mem_id'(k); r.addr = t_line_addr'(26'h200 + k);
      tick(1'b0, r);
      n = obs_cyc; er = pred_resp; rc = -1;
      for (int w = 0; w < 20 && rc < 0; w++) begin
        tick(1'b0, idle);
        n_tests += 2;
        if (obs_rsp.valid !== exp_rsp.valid || obs_rsp.id !== exp_rsp.id) begin n_fail++; $display("FAIL lat_rsp cyc=%0d got=%h want=%h", obs_cyc, obs_rsp, exp_rsp); end
        if (obs_busy !== exp_busy) begin n_fail++; $display("FAIL lat_busy cyc=%0d got=%b want=%b", obs_cyc, obs_busy, exp_busy); end
        if (obs_rsp.valid === 1'b1) begin
          rc = obs_cyc;
          n_tests++;
          if (obs_rsp.id !== t_mem_id'(k)) begin n_fail++; $display("FAIL lat_id got=%0d want=%0d", obs_rsp.id, k); end
        end
      end
      n_tests += 2;
      if (rc != er) begin n_fail++; $display("FAIL lat_pred k=%0d got=%0d want=%0d", k, rc - n, er - n); end
      if (rc - n < lo || rc - n > hi) begin n_fail++; $display("FAIL lat_range k=%0d got=%0d want=%0d..%0d", k, rc - n, lo, hi); end
    end
  endtask

  task automatic test_random();
    t_mem_req_pkt r;
    int id;
    id = 0;
    for (int i = 0; i < 400; i++) begin
      r = '0;
      if (i < 360 && $urandom_range(0, 2) == 0) begin
        r.valid = 1'b1;
        r.op    = ($urandom_range(0, 1) == 1) ? MEM_WR : MEM_RD;
        r.id    = t_mem_id'(id);
        r.addr  = t_line_addr'(26'h100 + $urandom_range(0, 7));
        if (r.op == MEM_WR) r.data = {$urandom, $urandom};
        id++;
      end
      tick(1'b0, r);
      n_tests += 3;
      if (obs_rsp.valid !== exp_rsp.valid || obs_rsp.op !== exp_rsp.op || obs_rsp.id !== exp_rsp.id || (exp_dk && obs_rsp.data !== exp_rsp.data)) begin n_fail++; $display("FAIL rand_rsp cyc=%0d got=%h want=%h", obs_cyc, obs_rsp, exp_rsp); end
      if (obs_busy !== exp_busy) begin n_fail++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", obs_cyc, obs_busy, exp_busy); end
      if (obs_ovf !== exp_ovf) begin n_fail++; $display("FAIL rand_ovf cyc=%0d got=%b want=%b", obs_cyc, obs_ovf, exp_ovf); end
    end
  endtask

  initial begin
    idle = '0; req = '0; reset = 1'b1;
    last_resp = -100; lfsr_m = 8'h01; ovf_m = 0; pred_resp = -1;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_read();
    test_write_read();
    test_burst(5);
    test_burst(6);
    tick(1'b1, idle);
    test_reset_in_wait();
    tick(1'b1, idle);
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
